// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_txn_arbiter_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Width of the shared phase timer: it is loaded with (count - 1), so it
    // only has to hold the largest of the three phase lengths minus one.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Round-robin successor of an index in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin requester selection: combinational pick starting at the
// pointer, pointer advanced past the finishing owner.
module spi_rr_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Next pointer: one past the owner whose transaction just finished.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = IDX_W'(rr_next(32'(last_i), NUM_REQ));
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // First active request at or after the pointer, wrapping.
    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr_q) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IDX_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI byte engine between NUM_REQ requesters, one multi-byte
// transaction at a time, with chip-select setup/hold/gap sequencing.
module spi_txn_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 4,
    parameter int SETUP   = 2,
    parameter int HOLD    = 2,
    parameter int GAP     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    output logic [NUM_REQ-1:0]            req_grant,
    input  logic [NUM_REQ*SPI_BYTE_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]            tx_take,
    output logic [SPI_BYTE_W-1:0]         rx_data,
    output logic [NUM_REQ-1:0]            rx_valid,
    output logic [NUM_REQ-1:0]            txn_done,
    output logic                          busy,
    output logic                          cs,
    output logic                          eng_start,
    output logic [SPI_BYTE_W-1:0]         eng_tx,
    input  logic                          eng_done,
    input  logic [SPI_BYTE_W-1:0]         eng_rx
);

    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = timer_width(SETUP, HOLD, GAP);
    localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(SETUP - 1);
    localparam logic [TMR_W-1:0] T_HOLD  = TMR_W'(HOLD - 1);
    localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(GAP - 1);

    state_t                    state_q;
    logic [IDX_W-1:0]          owner_q;
    logic [LEN_W-1:0]          cnt_q;
    logic [TMR_W-1:0]          tmr_q;
    logic [NUM_REQ-1:0]        req_grant_q, tx_take_q, rx_valid_q, txn_done_q;
    logic [SPI_BYTE_W-1:0]     rx_data_q, eng_tx_q;
    logic                      busy_q, cs_q, eng_start_q;

    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_any;
    logic                      rr_adv;
    logic [SPI_BYTE_W-1:0]     tx_sel;
    logic [LEN_W-1:0]          len_sel;
    logic [NUM_REQ-1:0]        owner_oh;

    assign rr_adv = (state_q == ST_HOLD) && (tmr_q == '0);

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk    (clk),
        .rst    (reset),
        .req_i  (req_valid),
        .adv_i  (rr_adv),
        .last_i (owner_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // Owner-selected views of the packed per-requester buses.
    always_comb begin
        tx_sel           = tx_data[int'(owner_q)*SPI_BYTE_W +: SPI_BYTE_W];
        len_sel          = req_len[int'(arb_idx)*LEN_W +: LEN_W];
        owner_oh         = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Transaction sequencer; all outputs registered, pulses default low.
    // The last SETUP cycle issues the first byte itself so that the first
    // eng_start lands exactly SETUP cycles after cs falls; SEND is only used
    // between bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            req_grant_q <= '0;
            tx_take_q   <= '0;
            rx_valid_q  <= '0;
            txn_done_q  <= '0;
            rx_data_q   <= '0;
            eng_tx_q    <= '0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b1;
            eng_start_q <= 1'b0;
        end else begin
            req_grant_q <= '0;
            tx_take_q   <= '0;
            rx_valid_q  <= '0;
            txn_done_q  <= '0;
            eng_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        req_grant_q <= arb_gnt;
                        owner_q     <= arb_idx;
                        cnt_q       <= len_sel;
                        cs_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        tmr_q       <= T_SETUP;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_q == '0) begin
                        eng_tx_q    <= tx_sel;
                        eng_start_q <= 1'b1;
                        tx_take_q   <= owner_oh;
                        state_q     <= ST_WAIT;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_SEND: begin
                    eng_tx_q    <= tx_sel;
                    eng_start_q <= 1'b1;
                    tx_take_q   <= owner_oh;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        rx_data_q  <= eng_rx;
                        rx_valid_q <= owner_oh;
                        if (cnt_q == '0) begin
                            tmr_q   <= T_HOLD;
                            state_q <= ST_HOLD;
                        end else begin
                            cnt_q   <= cnt_q - 1'b1;
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_q == '0) begin
                        cs_q       <= 1'b1;
                        txn_done_q <= owner_oh;
                        tmr_q      <= T_GAP;
                        state_q    <= ST_GAP;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_grant = req_grant_q;
    assign tx_take   = tx_take_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign txn_done  = txn_done_q;
    assign busy      = busy_q;
    assign cs        = cs_q;
    assign eng_start = eng_start_q;
    assign eng_tx    = eng_tx_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a behavioural byte engine.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ = 2;
    localparam int LEN_W   = 4;
    localparam int SETUP   = 2;
    localparam int HOLD    = 2;
    localparam int GAP     = 4;

    logic                     clk, reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ*8-1:0]     tx_data;
    logic [NUM_REQ-1:0]       tx_take;
    logic [7:0]               rx_data;
    logic [NUM_REQ-1:0]       rx_valid;
    logic [NUM_REQ-1:0]       txn_done;
    logic                     busy, cs, eng_start;
    logic [7:0]               eng_tx;
    logic                     eng_done;
    logic [7:0]               eng_rx;

    spi_txn_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .SETUP   (SETUP),
        .HOLD    (HOLD),
        .GAP     (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_grant (req_grant),
        .tx_data   (tx_data),
        .tx_take   (tx_take),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .txn_done  (txn_done),
        .busy      (busy),
        .cs        (cs),
        .eng_start (eng_start),
        .eng_tx    (eng_tx),
        .eng_done  (eng_done),
        .eng_rx    (eng_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural byte engine: done ~16 clocks after start, returns ~byte.
    logic       e_busy, e_done;
    logic [4:0] e_cnt;
    logic [7:0] e_byte, e_rx;
    logic       spur_done;
    logic [7:0] spur_rx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_busy <= 1'b0; e_done <= 1'b0; e_cnt <= '0; e_byte <= '0; e_rx <= '0;
        end else begin
            e_done <= 1'b0;
            if (eng_start) begin
                e_busy <= 1'b1; e_cnt <= 5'd15; e_byte <= eng_tx;
            end else if (e_busy) begin
                if (e_cnt == 0) begin
                    e_done <= 1'b1; e_rx <= ~e_byte; e_busy <= 1'b0;
                end else begin
                    e_cnt <= e_cnt - 5'd1;
                end
            end
        end
    end

    assign eng_done = e_done | spur_done;
    assign eng_rx   = e_done ? e_rx : spur_rx;

    // Scoreboard state: per-requester expected traffic.
    logic [7:0] txq    [NUM_REQ][$];
    logic [7:0] exp_tx [NUM_REQ][$];
    logic [7:0] exp_rx [NUM_REQ][$];
    int         exp_len[NUM_REQ][$];
    int         grant_log[$];
    logic [7:0] rx_log[$];
    int n_pass = 0, n_checks = 0;
    int n_start = 0, n_rx = 0, n_done = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (i >= 0 && i < NUM_REQ) v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: reference round-robin model plus pops of expected traffic.
    initial begin
        int owner, ptr, nbytes, cyc, fall_cyc, rise_cyc, last_rx_cyc, g, j;
        bit first, rise_valid, cs_prev;
        logic [NUM_REQ-1:0] prev_req;
        logic [7:0] ev;
        int el;
        owner = 0; ptr = 0; nbytes = 0; cyc = 0; fall_cyc = 0; rise_cyc = 0; last_rx_cyc = 0;
        first = 0; rise_valid = 0; cs_prev = 1; prev_req = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                ptr = 0; first = 0; rise_valid = 0; cs_prev = 1; prev_req = '0; nbytes = 0;
            end else begin
                if (req_grant != 0) begin
                    g = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        j = (ptr + k) % NUM_REQ;
                        if (g < 0 && prev_req[j]) g = j;
                    end
                    check(g >= 0 && req_grant == oh(g), "grant_rr", req_grant, oh(g));
                    check(busy && !cs, "grant_busy_cs", {busy, cs}, 2'b10);
                    if (rise_valid) check(cyc - rise_cyc >= GAP, "cs_gap", cyc - rise_cyc, GAP);
                    owner = (g >= 0) ? g : 0;
                    grant_log.push_back(owner);
                    fall_cyc = cyc; first = 1; nbytes = 0;
                end
                if (eng_start) begin
                    n_start++;
                    check(tx_take == oh(owner), "tx_take_owner", tx_take, oh(owner));
                    check(!cs && !e_busy, "start_cs_low_engine_idle", {cs, e_busy}, 0);
                    if (exp_tx[owner].size() == 0) check(0, "eng_tx_unexpected", eng_tx, 0);
                    else begin
                        ev = exp_tx[owner].pop_front();
                        check(eng_tx == ev, "eng_tx", eng_tx, ev);
                    end
                    if (first) begin
                        check(cyc - fall_cyc == SETUP, "setup_cycles", cyc - fall_cyc, SETUP);
                        first = 0;
                    end
                    nbytes++;
                end else if (tx_take != 0) begin
                    check(0, "take_without_start", tx_take, 0);
                end
                if (rx_valid != 0) begin
                    n_rx++;
                    rx_log.push_back(rx_data);
                    check(rx_valid == oh(owner), "rx_valid_owner", rx_valid, oh(owner));
                    if (exp_rx[owner].size() == 0) check(0, "rx_unexpected", rx_data, 0);
                    else begin
                        ev = exp_rx[owner].pop_front();
                        check(rx_data == ev, "rx_data", rx_data, ev);
                    end
                    last_rx_cyc = cyc;
                end
                if (txn_done != 0) begin
                    n_done++;
                    check(txn_done == oh(owner) && cs, "txn_done_owner_cs", {cs, txn_done}, {1'b1, oh(owner)});
                    if (exp_len[owner].size() == 0) check(0, "txn_unexpected", nbytes, 0);
                    else begin
                        el = exp_len[owner].pop_front();
                        check(nbytes == el, "txn_bytes", nbytes, el);
                    end
                    check(cyc - last_rx_cyc >= HOLD, "cs_hold", cyc - last_rx_cyc, HOLD);
                    ptr = (owner + 1) % NUM_REQ;
                    rise_cyc = cyc; rise_valid = 1;
                end else if (cs && !cs_prev) begin
                    check(0, "cs_rise_early", cs, 0);
                end
                cs_prev = cs;
                prev_req = req_valid;
            end
        end
    end

    // Requester side helpers.
    task automatic drive_tx();
        for (int i = 0; i < NUM_REQ; i++)
            tx_data[i*8 +: 8] = (txq[i].size() > 0) ? txq[i][0] : 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) req_valid[i] = 1'b0;
            if (tx_take[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        end
        drive_tx();
    endtask

    task automatic issue(input int id, input logic [7:0] b[$]);
        req_len[id*LEN_W +: LEN_W] = LEN_W'(b.size() - 1);
        foreach (b[k]) begin
            txq[id].push_back(b[k]);
            exp_tx[id].push_back(b[k]);
            exp_rx[id].push_back(~b[k]);
        end
        exp_len[id].push_back(b.size());
        req_valid[id] = 1'b1;
        drive_tx();
    endtask

    task automatic issue_rand(input int id, input int len);
        logic [7:0] b[$];
        for (int k = 0; k <= len; k++) b.push_back(8'($urandom));
        issue(id, b);
    endtask

    function automatic bit quiet();
        bit q;
        q = !busy && (req_valid == 0);
        for (int i = 0; i < NUM_REQ; i++) if (exp_len[i].size() != 0) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(input int limit, input string name);
        int t;
        t = 0;
        while (!quiet() && t < limit) begin step(); t++; end
        if (t >= limit) check(0, name, t, limit);
    endtask

    task automatic flush();
        for (int i = 0; i < NUM_REQ; i++) begin
            txq[i].delete(); exp_tx[i].delete(); exp_rx[i].delete(); exp_len[i].delete();
        end
        req_valid = '0;
        drive_tx();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        logic [7:0] b3[$];
        int s_start, s_rx, s_done, issued, t, mask;
        reset = 1'b1; req_valid = '0; req_len = '0; tx_data = '0; spur_done = 1'b0; spur_rx = '0;
        repeat (3) @(posedge clk);
        #1;
        check(cs == 1'b1 && busy == 1'b0, "reset_cs_busy", {cs, busy}, 2'b10);
        check({eng_start, req_grant, tx_take, rx_valid, txn_done} == 0, "reset_pulses",
              {eng_start, req_grant, tx_take, rx_valid, txn_done}, 0);
        check(eng_tx == 8'h00 && rx_data == 8'h00, "reset_data", {eng_tx, rx_data}, 0);
        reset = 1'b0;

        // Single 3-byte transaction with fixed bytes.
        s_start = n_start; s_rx = n_rx; s_done = n_done;
        b3 = '{8'hA5, 8'h5A, 8'h3C};
        issue(0, b3);
        wait_quiet(2000, "single_timeout");
        check(n_start - s_start == 3, "single_starts", n_start - s_start, 3);
        check(n_rx - s_rx == 3, "single_rx", n_rx - s_rx, 3);
        check(n_done - s_done == 1, "single_done", n_done - s_done, 1);
        check(rx_log.size() >= 3 && rx_log[rx_log.size()-3] == 8'h5A, "single_rx0", rx_log[rx_log.size()-3], 8'h5A);
        check(rx_log.size() >= 3 && rx_log[rx_log.size()-2] == 8'hA5, "single_rx1", rx_log[rx_log.size()-2], 8'hA5);
        check(rx_log.size() >= 3 && rx_log[rx_log.size()-1] == 8'hC3, "single_rx2", rx_log[rx_log.size()-1], 8'hC3);

        // Asynchronous reset in the middle of a byte.
        s_start = n_start;
        issue_rand(0, 2);
        t = 0;
        while (n_start == s_start && t < 200) begin step(); t++; end
        check(t < 200, "reset_txn_start_timeout", t, 200);
        repeat (5) step();
        check(cs == 1'b0, "cs_low_before_reset", cs, 0);
        #2 reset = 1'b1;
        #1;
        check(cs == 1'b1 && busy == 1'b0, "async_reset_cs_busy", {cs, busy}, 2'b10);
        check({eng_start, req_grant, tx_take, rx_valid, txn_done} == 0, "async_reset_pulses",
              {eng_start, req_grant, tx_take, rx_valid, txn_done}, 0);
        flush();
        repeat (2) step();
        reset = 1'b0;

        // Contention: both requesters keep asking for single bytes.
        grant_log.delete();
        issue_rand(0, 0);
        issue_rand(1, 0);
        issued = 2; t = 0;
        while (!(issued == 4 && quiet()) && t < 3000) begin
            step(); t++;
            for (int i = 0; i < NUM_REQ; i++)
                if (txn_done[i] && issued < 4) begin issue_rand(i, 0); issued++; end
        end
        check(t < 3000, "contention_timeout", t, 3000);
        check(grant_log.size() == 4, "contention_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) check(grant_log[k] == k % 2, "contention_order", grant_log[k], k % 2);

        // Maximum length transaction.
        s_start = n_start; s_done = n_done;
        issue_rand(1, 15);
        wait_quiet(3000, "maxlen_timeout");
        check(n_start - s_start == 16, "maxlen_starts", n_start - s_start, 16);
        check(n_done - s_done == 1, "maxlen_done", n_done - s_done, 1);

        // Request dropped right after grant still runs all bytes.
        s_start = n_start; s_done = n_done;
        issue_rand(0, 3);
        wait_quiet(2000, "drop_timeout");
        check(n_start - s_start == 4, "drop_starts", n_start - s_start, 4);
        check(n_done - s_done == 1, "drop_done", n_done - s_done, 1);

        // Spurious eng_done while idle and during setup.
        s_rx = n_rx; s_start = n_start;
        spur_rx = 8'($urandom); spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        repeat (3) step();
        check(n_rx == s_rx && !busy && cs, "spur_idle", {n_rx - s_rx, busy, cs}, 1);
        issue_rand(0, 1);
        t = 0;
        while (req_grant == 0 && t < 50) begin step(); t++; end
        check(t < 50, "spur_grant_timeout", t, 50);
        spur_rx = 8'($urandom); spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        wait_quiet(2000, "spur_setup_timeout");
        check(n_rx - s_rx == 2, "spur_setup_rx", n_rx - s_rx, 2);
        check(n_start - s_start == 2, "spur_setup_starts", n_start - s_start, 2);

        // Randomized rounds with staggered requests.
        for (int r = 0; r < 8; r++) begin
            mask = $urandom_range(1, 3);
            if (mask[0]) issue_rand(0, $urandom_range(0, 3));
            repeat ($urandom_range(0, 40)) step();
            if (mask[1]) issue_rand(1, $urandom_range(0, 3));
            wait_quiet(3000, "random_timeout");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
